// File: rtl/instr_register_pkg.sv
// instr_register_pkg: shared types for the instruction register file and its
// controller.
//   operand_t     - signed 32-bit operand
//   opcode_t      - instruction opcode (ZERO marks an empty/cleared entry)
//   address_t     - register file index (DEPTH = 2**ADDR_W entries)
//   instruction_t - one stored entry {opcode, operand A, operand B}
//   ctrl_state_t  - controller mode: INIT (clearing sweep) or RUN (queue active)
package instr_register_pkg;

  localparam int ADDR_W      = 5;
  localparam int NUM_ENTRIES = 2 ** ADDR_W;

  typedef logic signed [31:0] operand_t;
  typedef logic [ADDR_W-1:0]  address_t;

  typedef enum logic [3:0] {
    ZERO  = 4'd0,
    PASSA = 4'd1,
    PASSB = 4'd2,
    ADD   = 4'd3,
    SUB   = 4'd4,
    MULT  = 4'd5,
    DIV   = 4'd6,
    MOD   = 4'd7
  } opcode_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
  } instruction_t;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } ctrl_state_t;

  // Register file index after a, wrapping from the last entry back to 0.
  function automatic address_t addr_inc(input address_t a);
    return a + address_t'(1'b1);
  endfunction

endpackage

// File: rtl/instr_rr_arbiter.sv
// instr_rr_arbiter: combinational round-robin arbiter.
//   req     - per-requester request vector
//   enable  - when low no grant is issued
//   rr_ptr  - requester with highest priority this cycle
//   grant   - one-hot grant (all zero when nothing is granted)
//   gnt_idx - index of the granted requester (0 when nothing is granted)
module instr_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic               enable,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   gnt_idx
);

  logic [IDX_W:0]   sum_s;
  logic [IDX_W-1:0] idx_s;
  logic             found_s;

  // Scan requesters starting at rr_ptr and grant the first active one.
  always_comb begin
    grant   = {NUM_REQ{1'b0}};
    gnt_idx = {IDX_W{1'b0}};
    found_s = 1'b0;
    sum_s   = {(IDX_W+1){1'b0}};
    idx_s   = {IDX_W{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      // rr_ptr < NUM_REQ, so a single subtraction brings the sum back in range.
      sum_s = {1'b0, rr_ptr} + (IDX_W+1)'(i);
      if (sum_s >= (IDX_W+1)'(NUM_REQ)) begin
        sum_s = sum_s - (IDX_W+1)'(NUM_REQ);
      end else begin
        sum_s = sum_s;
      end
      idx_s = sum_s[IDX_W-1:0];
      if (enable && !found_s && req[idx_s]) begin
        grant[idx_s] = 1'b1;
        gnt_idx      = idx_s;
        found_s      = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/instr_register_ctrl.sv
// instr_register_ctrl: runs instr_register as a circular instruction queue.
//   clk, reset_n        - clock, asynchronous active-low reset
//   flush               - one-cycle pulse: drop queue contents, redo clearing sweep
//   req_valid/req_ready - per-requester write handshake (ready is a one-hot grant)
//   req_opcode/_operand_a/_operand_b - per-requester write fields
//   load_en, write_pointer, opcode, operand_a, operand_b - registered write port
//   read_pointer        - queue head address into instr_register
//   instruction_word    - instr_register read data at read_pointer
//   rd_valid/rd_ready   - consumer pop handshake, rd_instr = head instruction
//   occupancy           - entries granted and not yet popped
//   init_done           - high once the clearing sweep has finished (RUN)
module instr_register_ctrl
  import instr_register_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DEPTH   = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   flush,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  opcode_t                req_opcode    [NUM_REQ],
  input  operand_t               req_operand_a [NUM_REQ],
  input  operand_t               req_operand_b [NUM_REQ],
  output logic                   load_en,
  output address_t               write_pointer,
  output opcode_t                opcode,
  output operand_t               operand_a,
  output operand_t               operand_b,
  output address_t               read_pointer,
  input  instruction_t           instruction_word,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output instruction_t           rd_instr,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic                   init_done
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int OCC_W = $clog2(DEPTH) + 1;
  localparam address_t LAST_ADDR = address_t'(DEPTH - 1);

  ctrl_state_t      state_q, state_d;
  address_t         sweep_q, sweep_d;
  address_t         wr_ptr_q, wr_ptr_d;          // address of the next accepted write
  address_t         write_pointer_q, write_pointer_d;
  address_t         read_pointer_q, read_pointer_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             load_en_q, load_en_d;
  opcode_t          opcode_q, opcode_d;
  operand_t         operand_a_q, operand_a_d;
  operand_t         operand_b_q, operand_b_d;
  logic [IDX_W-1:0] rr_q, rr_d;
  logic             init_done_q, init_done_d;

  logic             in_run_s;
  logic             arb_en_s;
  logic [NUM_REQ-1:0] grant_s;
  logic [IDX_W-1:0] gnt_idx_s;
  logic             accept_s;
  logic             pop_s;
  logic [OCC_W-1:0] written_s;

  instr_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req     (req_valid),
    .enable  (arb_en_s),
    .rr_ptr  (rr_q),
    .grant   (grant_s),
    .gnt_idx (gnt_idx_s)
  );

  // Handshake qualification and read-side visibility.
  always_comb begin
    in_run_s  = (state_q == RUN);
    // A pop in the same cycle does not free space for a grant when full.
    arb_en_s  = in_run_s && !flush && (occ_q < OCC_W'(DEPTH));
    accept_s  = |(req_valid & grant_s);
    // An entry still being written this cycle is counted but not yet readable.
    written_s = occ_q - OCC_W'(load_en_q);
    rd_valid  = in_run_s && (written_s != {OCC_W{1'b0}});
    pop_s     = rd_valid && rd_ready && !flush;
  end

  // Next-state computation for the sweep, write port, pointers and occupancy.
  always_comb begin
    state_d         = state_q;
    sweep_d         = sweep_q;
    wr_ptr_d        = wr_ptr_q;
    write_pointer_d = write_pointer_q;
    read_pointer_d  = read_pointer_q;
    occ_d           = occ_q;
    load_en_d       = 1'b0;
    opcode_d        = opcode_q;
    operand_a_d     = operand_a_q;
    operand_b_d     = operand_b_q;
    rr_d            = rr_q;
    init_done_d     = init_done_q;

    case (state_q)
      INIT: begin
        if (flush) begin
          sweep_d         = address_t'(1'b0);
          write_pointer_d = address_t'(1'b0);
          occ_d           = {OCC_W{1'b0}};
        end else if (load_en_q && (write_pointer_q == LAST_ADDR)) begin
          // Last entry is being cleared this cycle; the queue opens next cycle.
          state_d         = RUN;
          write_pointer_d = address_t'(1'b0);
          wr_ptr_d        = address_t'(1'b0);
          init_done_d     = 1'b1;
        end else begin
          load_en_d       = 1'b1;
          write_pointer_d = sweep_q;
          sweep_d         = addr_inc(sweep_q);
          opcode_d        = ZERO;
          operand_a_d     = operand_t'(32'sd0);
          operand_b_d     = operand_t'(32'sd0);
        end
      end
      RUN: begin
        if (flush) begin
          state_d         = INIT;
          sweep_d         = address_t'(1'b0);
          wr_ptr_d        = address_t'(1'b0);
          write_pointer_d = address_t'(1'b0);
          read_pointer_d  = address_t'(1'b0);
          occ_d           = {OCC_W{1'b0}};
          init_done_d     = 1'b0;
        end else begin
          if (accept_s) begin
            load_en_d       = 1'b1;
            write_pointer_d = wr_ptr_q;
            wr_ptr_d        = addr_inc(wr_ptr_q);
            opcode_d        = req_opcode[gnt_idx_s];
            operand_a_d     = req_operand_a[gnt_idx_s];
            operand_b_d     = req_operand_b[gnt_idx_s];
            if (gnt_idx_s == IDX_W'(NUM_REQ - 1)) begin
              rr_d = {IDX_W{1'b0}};
            end else begin
              rr_d = gnt_idx_s + IDX_W'(1'b1);
            end
          end else begin
            load_en_d = 1'b0;
          end
          if (pop_s) begin
            read_pointer_d = addr_inc(read_pointer_q);
          end else begin
            read_pointer_d = read_pointer_q;
          end
          occ_d = occ_q + OCC_W'(accept_s) - OCC_W'(pop_s);
        end
      end
      default: begin
        state_d     = INIT;
        sweep_d     = address_t'(1'b0);
        init_done_d = 1'b0;
      end
    endcase
  end

  // State and registered write-port outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= INIT;
      sweep_q         <= address_t'(1'b0);
      wr_ptr_q        <= address_t'(1'b0);
      write_pointer_q <= address_t'(1'b0);
      read_pointer_q  <= address_t'(1'b0);
      occ_q           <= {OCC_W{1'b0}};
      load_en_q       <= 1'b0;
      opcode_q        <= ZERO;
      operand_a_q     <= operand_t'(32'sd0);
      operand_b_q     <= operand_t'(32'sd0);
      rr_q            <= {IDX_W{1'b0}};
      init_done_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      sweep_q         <= sweep_d;
      wr_ptr_q        <= wr_ptr_d;
      write_pointer_q <= write_pointer_d;
      read_pointer_q  <= read_pointer_d;
      occ_q           <= occ_d;
      load_en_q       <= load_en_d;
      opcode_q        <= opcode_d;
      operand_a_q     <= operand_a_d;
      operand_b_q     <= operand_b_d;
      rr_q            <= rr_d;
      init_done_q     <= init_done_d;
    end
  end

  assign req_ready     = grant_s;
  assign load_en       = load_en_q;
  assign write_pointer = write_pointer_q;
  assign opcode        = opcode_q;
  assign operand_a     = operand_a_q;
  assign operand_b     = operand_b_q;
  assign read_pointer  = read_pointer_q;
  assign occupancy     = occ_q;
  assign init_done     = init_done_q;
  assign rd_instr      = instruction_word;

endmodule

// File: doc/instr_register_ctrl.md
Name: instr_register_ctrl

Overview:
Controller that shares the instr_register write port between NUM_REQ requesters and sequences its read port, so the register file behaves as a circular instruction queue.
- Write side: valid/ready handshake per requester, round-robin arbitration, auto-incrementing write_pointer.
- Read side: rd_valid/rd_ready handshake that advances read_pointer.
- After reset or flush, the block sweeps every entry to a ZERO instruction before accepting traffic.
- Sits between the stimulus producers/consumer and instr_register, and drives its load_en, write_pointer, read_pointer and operand/opcode inputs.

Parameters:
NUM_REQ, 2, number of write requesters (>=2)
DEPTH, 32, register entries; must equal 2**$bits(address_t)

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
flush  input  1  single-cycle pulse; restarts the INIT sweep
req_valid  input  NUM_REQ  per-requester write request
req_ready  output  NUM_REQ  one-hot grant, combinational
req_opcode  input  NUM_REQ x opcode_t  per-requester opcode
req_operand_a  input  NUM_REQ x operand_t  per-requester operand A
req_operand_b  input  NUM_REQ x operand_t  per-requester operand B
load_en  output  1  write strobe to instr_register
write_pointer  output  address_t  write address
opcode  output  opcode_t  write opcode
operand_a  output  operand_t  write operand A
operand_b  output  operand_t  write operand B
read_pointer  output  address_t  read address
instruction_word  input  instruction_t  register read data at read_pointer
rd_valid  output  1  queue head available
rd_ready  input  1  consumer pop
rd_instr  output  instruction_t  head instruction (= instruction_word)
occupancy  output  $clog2(DEPTH)+1  entries granted and not yet popped
init_done  output  1  high in RUN

Behaviour:
- Reset (async, reset_n=0): state=INIT, sweep index=0, write_pointer=0, read_pointer=0, occupancy=0, load_en=0, opcode=ZERO, operands=0, rr priority=requester 0, init_done=0.
- All write-port outputs are registered. req_ready, rd_valid and rd_instr are combinational.
- INIT state:
  - Each cycle: load_en=1, write_pointer=sweep index, opcode=ZERO, operand_a=0, operand_b=0.
  - After the write to index DEPTH-1, go to RUN next cycle. Then load_en=0, write_pointer=0, init_done=1.
  - req_ready=0 and rd_valid=0 throughout INIT.
- RUN state, grant:
  - Search requesters starting at the rr pointer; grant the first one with req_valid=1.
  - A grant is issued only if occupancy<DEPTH and flush=0. A same-cycle pop does not unblock a full queue.
- RUN state, accept (req_valid&req_ready at edge N):
  - During cycle N+1: load_en=1, write_pointer=wp, fields copied from the granted requester.
  - wp increments modulo DEPTH (31 wraps to 0).
  - rr pointer becomes (granted+1) mod NUM_REQ.
  - No accept in a cycle: load_en=0 next cycle.
- Requester rule: fields must be held stable while req_valid=1 and req_ready=0.
- Occupancy:
  - Next value = occupancy + accept - pop.
  - Accept and pop in the same cycle leave it unchanged.
- Read side:
  - written = occupancy - load_en; rd_valid = (written != 0) in RUN.
  - Pop = rd_valid&rd_ready. It increments read_pointer modulo DEPTH at the edge.
  - rd_ready while rd_valid=0 is ignored.
- Latency: an accept at edge N into an empty queue gives rd_valid=1 in cycle N+2. Throughput is one write and one read per cycle.
- Flush in RUN:
  - No grant and no pop in the flush cycle.
  - Next cycle: state=INIT, sweep index=0, both pointers=0, occupancy=0, init_done=0.
  - A load_en already registered still completes.
- Flush in INIT: the sweep restarts at index 0.

Decomposition:
- instr_register_pkg (existing) keeps operand_t, opcode_t, address_t, instruction_t.
- Add ctrl_state_t enum {INIT, RUN} to that package.
- One sub-module, instr_rr_arbiter: a parameterized round-robin arbiter.
  - Inputs: req, enable, rr pointer.
  - Outputs: one-hot grant and granted index.

Test Plan:
- Release reset → load_en for 32 cycles with write_pointer 0..31, opcode ZERO, operands 0; init_done=1 in cycle 33; req_ready=0 until then.
- Req0 ADD a=5 b=3 accepted → next cycle load_en=1, write_pointer=0; rd_valid 2 cycles after accept, rd_instr={ADD,5,3}; pop → read_pointer=1, occupancy=0.
- Both requesters held valid for 4 grants → grants 0,1,0,1 at write_pointer 0,1,2,3.
- 32 accepts without pops → occupancy=32, req_ready=0 even with a pop that cycle; next cycle grant resumes and write_pointer wraps 31→0.
- Occupancy=5, accept and pop in the same cycle → occupancy stays 5, both pointers advance.
- Flush at occupancy=10 → rd_valid=0 next cycle, full 32-cycle sweep, pointers=0; reset_n=0 mid-sweep → load_en=0 immediately, sweep restarts from 0 after release.
